// File: rtl/pht_pkg.sv
// Shared types and helpers for the pattern history table port arbiter.
package pht_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'd0;
  localparam ctr_t WNT = 2'd1;
  localparam ctr_t WT  = 2'd2;
  localparam ctr_t ST  = 2'd3;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } arb_state_t;

  function automatic ctr_t sat_update(input ctr_t c, input logic taken);
    if (taken) return (c == ST)  ? ST  : ctr_t'(c + 2'd1);
    else       return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/pht_upd_fifo.sv
// Small update FIFO holding {index, taken} entries awaiting a table RMW.
module pht_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;

  assign rdata = mem[rd_ptr];
  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

  // NOTE: storage has no reset; the pointers and count alone define which entries are live.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pht_port_arbiter.sv
// Single-port PHT sequencer: lookups by default, queued updates drained as two-cycle RMWs.
module pht_port_arbiter
  import pht_pkg::*;
#(
  parameter int IDX_W        = 10,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             STALL,
  input  logic             lk_valid,
  input  logic [IDX_W-1:0] lk_index,
  output logic             lk_grant,
  output logic             lk_rvalid,
  output logic             lk_pred,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_index,
  input  logic             upd_taken,
  output logic             upd_ready,
  output logic             tbl_en,
  output logic             tbl_we,
  output logic [IDX_W-1:0] tbl_addr,
  output logic [1:0]       tbl_wdata,
  input  logic [1:0]       tbl_rdata,
  output logic [15:0]      drop_count
);

  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

  arb_state_t       state, state_nxt;
  logic [STV_W-1:0] starve;
  logic             lk_req, force_rmw, start_rmw, pop;
  logic             grant, en, we;
  logic             fifo_full, fifo_empty;
  logic [IDX_W:0]   head;
  logic [IDX_W-1:0] head_index;
  logic             head_taken;

  assign head_index = head[IDX_W:1];
  assign head_taken = head[0];
  assign lk_req     = lk_valid & ~STALL;
  assign force_rmw  = fifo_full | (starve == STARVE_MAX);
  assign pop        = (state == RMW_WR);
  // The write cycle frees the head slot, so a full FIFO can still take an entry then.
  assign upd_ready  = ~fifo_full | pop;

  pht_upd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (IDX_W + 1)
  ) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (upd_valid & upd_ready),
    .pop   (pop),
    .wdata ({upd_index, upd_taken}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    en        = 1'b0;
    we        = 1'b0;
    start_rmw = 1'b0;
    tbl_addr  = lk_index;
    tbl_wdata = SNT;
    case (state)
      IDLE: begin
        if (!fifo_empty && (!lk_req || force_rmw)) begin
          start_rmw = 1'b1;
          en        = 1'b1;
          tbl_addr  = head_index;
          state_nxt = RMW_WR;
        end else if (lk_req) begin
          grant = 1'b1;
          en    = 1'b1;
        end
      end
      RMW_WR: begin
        en        = 1'b1;
        we        = 1'b1;
        tbl_addr  = head_index;
        tbl_wdata = sat_update(tbl_rdata, head_taken);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Port strobes are forced low while reset is asserted, even mid-RMW.
  assign lk_grant = grant & RESET;
  assign tbl_en   = en & RESET;
  assign tbl_we   = we & RESET;

  // Prediction comes straight from the SRAM output register, qualified by the registered valid.
  assign lk_pred  = lk_rvalid & tbl_rdata[1];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      starve     <= '0;
      lk_rvalid  <= 1'b0;
      drop_count <= '0;
    end else begin
      state     <= state_nxt;
      lk_rvalid <= grant;
      if (fifo_empty || start_rmw)
        starve <= '0;
      else if (grant && starve != STARVE_MAX)
        starve <= starve + 1'b1;
      if (lk_req && !grant && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pht_port_arbiter.sv
// Scenario bench for pht_port_arbiter with a behavioural table SRAM and a write scoreboard.
module tb_pht_port_arbiter;
  import pht_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       STALL = 1'b0;
  logic       lk_valid = 1'b0;
  logic [9:0] lk_index = '0;
  logic       upd_valid = 1'b0;
  logic [9:0] upd_index = '0;
  logic       upd_taken = 1'b0;
  logic       lk_grant, lk_rvalid, lk_pred, upd_ready, tbl_en, tbl_we;
  logic [9:0] tbl_addr;
  logic [1:0] tbl_wdata;
  logic [1:0] tbl_rdata = '0;
  logic [15:0] drop_count;

  pht_port_arbiter #(.IDX_W(10), .DEPTH(4), .STARVE_LIMIT(8)) dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL),
    .lk_valid(lk_valid), .lk_index(lk_index), .lk_grant(lk_grant),
    .lk_rvalid(lk_rvalid), .lk_pred(lk_pred),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
    .upd_ready(upd_ready),
    .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_wdata(tbl_wdata), .tbl_rdata(tbl_rdata), .drop_count(drop_count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [1:0] init_val(int i);
    return 2'(i ^ (i >> 2));
  endfunction

  // Table SRAM model: registered read, one access per cycle, plus a bench preload port.
  logic [1:0] mem [1024];
  logic       mem_ready = 1'b0;
  logic       pre_en = 1'b0;
  logic [9:0] pre_addr = '0;
  logic [1:0] pre_data = '0;

  always @(posedge CLK) begin
    if (!mem_ready) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end
    if (pre_en) mem[pre_addr] <= pre_data;
    if (tbl_en) begin
      if (tbl_we) mem[tbl_addr] <= tbl_wdata;
      else        tbl_rdata <= mem[tbl_addr];
    end
  end

  typedef struct packed {
    logic [9:0] addr;
    logic [1:0] data;
  } wr_t;

  wr_t        wq[$];
  logic [1:0] shadow [1024];
  logic       exp_lk_now = 1'b0, exp_lk_prev = 1'b0;
  logic       exp_pred_now = 1'b0, exp_pred_prev = 1'b0;
  int         exp_drop = 0;
  int         total = 0;
  int         bad = 0;

  // Called at the falling edge: retire scoreboard entries, then move to just after the next rising edge.
  task automatic tick();
    if (tbl_en === 1'b1 && tbl_we === 1'b1) begin
      total++;
      if (wq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got addr=%h data=%0d exp=none", tbl_addr, tbl_wdata);
      end else begin
        wr_t e;
        e = wq.pop_front();
        if ({tbl_addr, tbl_wdata} !== e) begin
          bad++;
          $display("FAIL table_write got addr=%h data=%0d exp addr=%h data=%0d",
                   tbl_addr, tbl_wdata, e.addr, e.data);
        end
      end
    end
    total++;
    if (lk_rvalid !== exp_lk_prev || (exp_lk_prev && lk_pred !== exp_pred_prev)) begin
      bad++;
      $display("FAIL lookup_result got rvalid=%b pred=%b exp rvalid=%b pred=%b",
               lk_rvalid, lk_pred, exp_lk_prev, exp_pred_prev);
    end
    exp_lk_prev   = exp_lk_now;
    exp_pred_prev = exp_pred_now;
    exp_lk_now    = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_lookup(input logic [9:0] idx);
    exp_lk_now   = 1'b1;
    exp_pred_now = mem[idx][1];
  endtask

  task automatic push_update(input logic [9:0] idx, input logic taken);
    upd_valid   = 1'b1;
    upd_index   = idx;
    upd_taken   = taken;
    shadow[idx] = sat_update(shadow[idx], taken);
    wq.push_back('{addr: idx, data: shadow[idx]});
  endtask

  task automatic poke(input logic [9:0] idx, input logic [1:0] val);
    pre_en      = 1'b1;
    pre_addr    = idx;
    pre_data    = val;
    shadow[idx] = val;
    @(negedge CLK);
    tick();
    pre_en = 1'b0;
  endtask

  task automatic drain(input int bound);
    logic done;
    done = 1'b0;
    upd_valid = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge CLK);
      done = (wq.size() == 0) && (tbl_en !== 1'b1);
      tick();
      if (done) break;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL drain_timeout got pending=%0d exp=0", wq.size());
    end
  endtask

  task automatic test_reset();
    #2 RESET = 1'b0;
    lk_valid = 1'b1;
    lk_index = 10'h003;
    @(negedge CLK);
    total++;
    if ({tbl_en, tbl_we, lk_grant} !== 3'b000) begin
      bad++; $display("FAIL reset_port got en/we/grant=%b exp=000", {tbl_en, tbl_we, lk_grant});
    end
    total++;
    if ({lk_rvalid, lk_pred} !== 2'b00) begin
      bad++; $display("FAIL reset_lookup got rvalid/pred=%b exp=00", {lk_rvalid, lk_pred});
    end
    total++;
    if (drop_count !== 16'd0 || upd_ready !== 1'b1) begin
      bad++; $display("FAIL reset_counters got drop=%0d ready=%b exp drop=0 ready=1", drop_count, upd_ready);
    end
    lk_valid = 1'b0;
    tick();
    @(negedge CLK);
    tick();
    RESET = 1'b1;
    exp_drop = 0;
  endtask

  task automatic test_lookup_stream();
    for (int i = 0; i < 12; i++) begin
      lk_valid = 1'b1;
      lk_index = 10'(i * 37 + 1);
      STALL    = (i == 5);
      @(negedge CLK);
      total++;
      if (i == 5) begin
        if ({lk_grant, tbl_en} !== 2'b00) begin
          bad++; $display("FAIL stall_no_lookup got grant/en=%b exp=00", {lk_grant, tbl_en});
        end
      end else begin
        if ({lk_grant, tbl_en, tbl_we, tbl_addr} !== {3'b110, lk_index}) begin
          bad++; $display("FAIL lookup_grant got grant/en/we=%b addr=%h exp 110 addr=%h",
                          {lk_grant, tbl_en, tbl_we}, tbl_addr, lk_index);
        end
        expect_lookup(lk_index);
      end
      tick();
    end
    lk_valid = 1'b0;
    STALL    = 1'b0;
    @(negedge CLK);
    total++;
    if (drop_count !== 16'(exp_drop)) begin
      bad++; $display("FAIL stream_drop got=%0d exp=%0d", drop_count, exp_drop);
    end
    tick();
  endtask

  task automatic test_single_rmw();
    poke(10'h005, WNT);
    push_update(10'h005, 1'b1);
    @(negedge CLK);
    total++;
    if ({upd_ready, tbl_en} !== 2'b10) begin
      bad++; $display("FAIL rmw_push_cycle got ready/en=%b exp=10", {upd_ready, tbl_en});
    end
    tick();
    upd_valid = 1'b0;
    @(negedge CLK);
    total++;
    if ({tbl_en, tbl_we, tbl_addr} !== {2'b10, 10'h005}) begin
      bad++; $display("FAIL rmw_read got en/we=%b addr=%h exp 10 addr=005", {tbl_en, tbl_we}, tbl_addr);
    end
    tick();
    @(negedge CLK);
    total++;
    if ({tbl_en, tbl_we, tbl_addr, tbl_wdata} !== {2'b11, 10'h005, WT}) begin
      bad++; $display("FAIL rmw_write got en/we=%b addr=%h data=%0d exp 11 addr=005 data=2",
                      {tbl_en, tbl_we}, tbl_addr, tbl_wdata);
    end
    tick();
    @(negedge CLK);
    total++;
    if (tbl_en !== 1'b0 || mem[10'h005] !== WT) begin
      bad++; $display("FAIL rmw_done got en=%b mem=%0d exp en=0 mem=2", tbl_en, mem[10'h005]);
    end
    tick();
  endtask

  task automatic test_starve();
    for (int c = 0; c < 12; c++) begin
      lk_valid = 1'b1;
      lk_index = 10'(10'h100 + c);
      if (c == 0) push_update(10'h02A, 1'b0);
      else        upd_valid = 1'b0;
      @(negedge CLK);
      total++;
      if (c == 9) begin
        exp_drop++;
        if ({lk_grant, tbl_en, tbl_we, tbl_addr} !== {3'b010, 10'h02A}) begin
          bad++; $display("FAIL starve_force got grant/en/we=%b addr=%h exp 010 addr=02a",
                          {lk_grant, tbl_en, tbl_we}, tbl_addr);
        end
      end else if (c == 10) begin
        exp_drop++;
        if ({lk_grant, tbl_we} !== 2'b01) begin
          bad++; $display("FAIL starve_write got grant/we=%b exp=01", {lk_grant, tbl_we});
        end
      end else begin
        if (lk_grant !== 1'b1) begin
          bad++; $display("FAIL starve_lookup_wins cycle=%0d got grant=%b exp=1", c, lk_grant);
        end
        expect_lookup(lk_index);
      end
      tick();
    end
    lk_valid = 1'b0;
    @(negedge CLK);
    total++;
    if (drop_count !== 16'(exp_drop)) begin
      bad++; $display("FAIL starve_drop got=%0d exp=%0d", drop_count, exp_drop);
    end
    tick();
  endtask

  task automatic test_fifo_full();
    logic [9:0] u [5];
    for (int k = 0; k < 5; k++) u[k] = 10'(10'h200 + k * 3);
    for (int c = 0; c < 6; c++) begin
      lk_valid = 1'b1;
      lk_index = 10'(10'h080 + c);
      if (c < 4 || c == 5) push_update(u[c < 4 ? c : 4], c[0]);
      else begin
        upd_valid = 1'b1; upd_index = u[4]; upd_taken = 1'b1;
      end
      @(negedge CLK);
      total++;
      if (c < 4) begin
        if ({upd_ready, lk_grant} !== 2'b11) begin
          bad++; $display("FAIL fill_push cycle=%0d got ready/grant=%b exp=11", c, {upd_ready, lk_grant});
        end
        expect_lookup(lk_index);
      end else if (c == 4) begin
        exp_drop++;
        if ({upd_ready, lk_grant, tbl_en, tbl_we, tbl_addr} !== {4'b0010, u[0]}) begin
          bad++; $display("FAIL full_force got ready/grant/en/we=%b addr=%h exp 0010 addr=%h",
                          {upd_ready, lk_grant, tbl_en, tbl_we}, tbl_addr, u[0]);
        end
      end else begin
        exp_drop++;
        if ({upd_ready, lk_grant, tbl_we, tbl_addr} !== {3'b101, u[0]}) begin
          bad++; $display("FAIL pop_cycle_push got ready/grant/we=%b addr=%h exp 101 addr=%h",
                          {upd_ready, lk_grant, tbl_we}, tbl_addr, u[0]);
        end
      end
      tick();
    end
    lk_valid = 1'b0;
    drain(30);
    @(negedge CLK);
    total++;
    if (drop_count !== 16'(exp_drop)) begin
      bad++; $display("FAIL full_drop got=%0d exp=%0d", drop_count, exp_drop);
    end
    tick();
  endtask

  task automatic test_saturation();
    poke(10'h3FF, ST);
    poke(10'h000, SNT);
    push_update(10'h3FF, 1'b1);
    @(negedge CLK);
    total++;
    if (upd_ready !== 1'b1) begin
      bad++; $display("FAIL sat_push_hi got ready=%b exp=1", upd_ready);
    end
    tick();
    push_update(10'h000, 1'b0);
    @(negedge CLK);
    total++;
    if (upd_ready !== 1'b1) begin
      bad++; $display("FAIL sat_push_lo got ready=%b exp=1", upd_ready);
    end
    tick();
    drain(20);
    @(negedge CLK);
    total++;
    if (mem[10'h3FF] !== ST || mem[10'h000] !== SNT) begin
      bad++; $display("FAIL sat_table got hi=%0d lo=%0d exp hi=3 lo=0", mem[10'h3FF], mem[10'h000]);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    poke(10'h007, WNT);
    push_update(10'h007, 1'b1);
    @(negedge CLK);
    tick();
    push_update(10'h008, 1'b0);
    @(negedge CLK);
    total++;
    if ({tbl_en, tbl_we, tbl_addr} !== {2'b10, 10'h007}) begin
      bad++; $display("FAIL abort_read got en/we=%b addr=%h exp 10 addr=007", {tbl_en, tbl_we}, tbl_addr);
    end
    tick();
    RESET     = 1'b0;
    upd_valid = 1'b0;
    @(negedge CLK);
    total++;
    if ({tbl_en, tbl_we, lk_rvalid} !== 3'b000) begin
      bad++; $display("FAIL abort_no_write got en/we/rvalid=%b exp=000", {tbl_en, tbl_we, lk_rvalid});
    end
    wq.delete();
    shadow[10'h007] = mem[10'h007];
    shadow[10'h008] = mem[10'h008];
    exp_drop = 0;
    tick();
    RESET = 1'b1;
    @(negedge CLK);
    total++;
    if ({upd_ready, mem[10'h007]} !== {1'b1, WNT} || drop_count !== 16'd0) begin
      bad++; $display("FAIL abort_after got ready=%b mem=%0d drop=%0d exp ready=1 mem=1 drop=0",
                      upd_ready, mem[10'h007], drop_count);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      total++;
      if (tbl_en !== 1'b0) begin
        bad++; $display("FAIL abort_queue_discarded got en=%b exp=0", tbl_en);
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) shadow[i] = init_val(i);
    test_reset();
    test_lookup_stream();
    test_single_rmw();
    test_starve();
    test_fifo_full();
    test_saturation();
    test_reset_abort();
    total++;
    if (wq.size() != 0) begin
      bad++; $display("FAIL leftover_writes got=%0d exp=0", wq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
